// File: rtl/pattern_gen.sv
// pattern_gen: two-stage video test-pattern generator (bars, ramp, checker, bouncing box, solid).
// Optional macro PATTERN_GEN_BORDER_EN forces a one-pixel white frame around the visible area.
module pattern_gen #(
  parameter int H_ACTIVE   = 480,
  parameter int V_ACTIVE   = 272,
  parameter int COORD_W    = 10,
  parameter int COLOR_W    = 8,
  parameter int NUM_BARS   = 8,
  parameter int CHECK_LOG2 = 5,
  parameter int BOX_SIZE   = 32,
  parameter int RAMP_SHIFT = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [COORD_W-1:0]     pixel_x,
  input  logic [COORD_W-1:0]     pixel_y,
  input  logic                   active,
  input  logic                   frame_start,
  input  logic [2:0]             mode,
  input  logic [3*COLOR_W-1:0]   solid_rgb,
  output logic [COLOR_W-1:0]     red,
  output logic [COLOR_W-1:0]     green,
  output logic [COLOR_W-1:0]     blue,
  output logic                   out_active
);

  localparam int                 BAR_W        = H_ACTIVE / NUM_BARS;
  localparam logic [COORD_W-1:0] BAR_LAST     = COORD_W'(BAR_W - 1);
  localparam logic [2:0]         BAR_IDX_LAST = 3'(NUM_BARS - 1);
  localparam logic [COORD_W-1:0] BOX_X_MAX    = COORD_W'(H_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W-1:0] BOX_Y_MAX    = COORD_W'(V_ACTIVE - BOX_SIZE);
  localparam logic [COORD_W:0]   BOX_SPAN     = (COORD_W+1)'(BOX_SIZE);
  localparam logic [COORD_W-1:0] C_ONE        = COORD_W'(1);
  localparam logic [COLOR_W-1:0] C_ON         = {COLOR_W{1'b1}};
  localparam logic [COLOR_W-1:0] C_OFF        = {COLOR_W{1'b0}};

  logic [COORD_W-1:0]   r_pix_in_bar;
  logic [2:0]           r_bar_idx;
  logic [2:0]           r_mode_q;
  logic [3*COLOR_W-1:0] r_solid_q;
  logic [COORD_W-1:0]   r_box_x;
  logic [COORD_W-1:0]   r_box_y;
  logic                 r_box_dx_neg;
  logic                 r_box_dy_neg;

  logic [COORD_W-1:0]   r_s1_x;
  logic [COORD_W-1:0]   r_s1_y;
  logic                 r_s1_active;
  logic [2:0]           r_s1_bar;

  logic [COORD_W:0]     w_box_x_nxt;
  logic [COORD_W:0]     w_box_y_nxt;
  logic [2:0]           w_bar_on;
  logic                 w_in_box;
  logic                 w_checker;
  logic [COORD_W-1:0]   w_ramp_sh;
  logic [COLOR_W-1:0]   w_ramp;
  logic [COLOR_W-1:0]   w_pat_r;
  logic [COLOR_W-1:0]   w_pat_g;
  logic [COLOR_W-1:0]   w_pat_b;
  logic [COLOR_W-1:0]   w_fin_r;
  logic [COLOR_W-1:0]   w_fin_g;
  logic [COLOR_W-1:0]   w_fin_b;

  // Returns {moving_negative, next_position}; reverses at either wall without overshooting.
  function automatic logic [COORD_W:0] bounce_step(input logic [COORD_W-1:0] pos,
                                                   input logic               neg,
                                                   input logic [COORD_W-1:0] lim);
    logic [COORD_W:0] nxt;
    if (!neg)
      nxt = (pos == lim) ? {1'b1, pos - C_ONE} : {1'b0, pos + C_ONE};
    else
      nxt = (pos == '0) ? {1'b0, pos + C_ONE} : {1'b1, pos - C_ONE};
    return nxt;
  endfunction

  assign w_box_x_nxt = bounce_step(r_box_x, r_box_dx_neg, BOX_X_MAX);
  assign w_box_y_nxt = bounce_step(r_box_y, r_box_dy_neg, BOX_Y_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mode_q     <= 3'd0;
      r_solid_q    <= '0;
      r_box_x      <= '0;
      r_box_y      <= '0;
      r_box_dx_neg <= 1'b0;
      r_box_dy_neg <= 1'b0;
    end else if (frame_start) begin
      r_mode_q                    <= mode;
      r_solid_q                   <= solid_rgb;
      {r_box_dx_neg, r_box_x}     <= w_box_x_nxt;
      {r_box_dy_neg, r_box_y}     <= w_box_y_nxt;
    end
  end

  // Bar position tracks the run of active pixels since the last blanking gap.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pix_in_bar <= '0;
      r_bar_idx    <= 3'd0;
    end else if (!active) begin
      r_pix_in_bar <= '0;
      r_bar_idx    <= 3'd0;
    end else if (r_pix_in_bar == BAR_LAST) begin
      r_pix_in_bar <= '0;
      if (r_bar_idx != BAR_IDX_LAST)
        r_bar_idx <= r_bar_idx + 3'd1;
    end else begin
      r_pix_in_bar <= r_pix_in_bar + C_ONE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1_x      <= '0;
      r_s1_y      <= '0;
      r_s1_active <= 1'b0;
      r_s1_bar    <= 3'd0;
    end else begin
      r_s1_x      <= pixel_x;
      r_s1_y      <= pixel_y;
      r_s1_active <= active;
      r_s1_bar    <= r_bar_idx;
    end
  end

  always_comb begin
    w_bar_on = 3'b000;
    case (r_s1_bar)
      3'd0:    w_bar_on = 3'b111;
      3'd1:    w_bar_on = 3'b110;
      3'd2:    w_bar_on = 3'b011;
      3'd3:    w_bar_on = 3'b010;
      3'd4:    w_bar_on = 3'b101;
      3'd5:    w_bar_on = 3'b100;
      3'd6:    w_bar_on = 3'b001;
      default: w_bar_on = 3'b000;
    endcase
  end

  assign w_in_box = (r_s1_x >= r_box_x) && ({1'b0, r_s1_x} < ({1'b0, r_box_x} + BOX_SPAN)) &&
                    (r_s1_y >= r_box_y) && ({1'b0, r_s1_y} < ({1'b0, r_box_y} + BOX_SPAN));
  assign w_checker = r_s1_x[CHECK_LOG2] ^ r_s1_y[CHECK_LOG2];
  assign w_ramp_sh = r_s1_x >> RAMP_SHIFT;
  assign w_ramp    = COLOR_W'(w_ramp_sh);

  always_comb begin
    w_pat_r = C_OFF;
    w_pat_g = C_OFF;
    w_pat_b = C_OFF;
    case (r_mode_q)
      3'd0: begin
        w_pat_r = {COLOR_W{w_bar_on[2]}};
        w_pat_g = {COLOR_W{w_bar_on[1]}};
        w_pat_b = {COLOR_W{w_bar_on[0]}};
      end
      3'd1: begin
        w_pat_r = w_ramp;
        w_pat_g = w_ramp;
        w_pat_b = w_ramp;
      end
      3'd2: begin
        w_pat_r = w_checker ? C_ON : C_OFF;
        w_pat_g = w_checker ? C_ON : C_OFF;
        w_pat_b = w_checker ? C_ON : C_OFF;
      end
      3'd3: begin
        w_pat_r = w_in_box ? C_ON : C_OFF;
        w_pat_g = w_in_box ? C_ON : C_OFF;
        w_pat_b = C_ON;
      end
      3'd4: begin
        w_pat_r = r_solid_q[3*COLOR_W-1 -: COLOR_W];
        w_pat_g = r_solid_q[2*COLOR_W-1 -: COLOR_W];
        w_pat_b = r_solid_q[COLOR_W-1:0];
      end
      default: begin
        w_pat_r = C_OFF;
        w_pat_g = C_OFF;
        w_pat_b = C_OFF;
      end
    endcase
  end

`ifdef PATTERN_GEN_BORDER_EN
  localparam logic [COORD_W-1:0] H_LAST = COORD_W'(H_ACTIVE - 1);
  localparam logic [COORD_W-1:0] V_LAST = COORD_W'(V_ACTIVE - 1);

  logic w_on_border;
  assign w_on_border = (r_s1_x == '0) || (r_s1_x == H_LAST) ||
                       (r_s1_y == '0) || (r_s1_y == V_LAST);

  always_comb begin
    w_fin_r = w_pat_r;
    w_fin_g = w_pat_g;
    w_fin_b = w_pat_b;
    if (w_on_border) begin
      w_fin_r = C_ON;
      w_fin_g = C_ON;
      w_fin_b = C_ON;
    end
  end
`else
  assign w_fin_r = w_pat_r;
  assign w_fin_g = w_pat_g;
  assign w_fin_b = w_pat_b;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      red        <= '0;
      green      <= '0;
      blue       <= '0;
      out_active <= 1'b0;
    end else begin
      red        <= r_s1_active ? w_fin_r : C_OFF;
      green      <= r_s1_active ? w_fin_g : C_OFF;
      blue       <= r_s1_active ? w_fin_b : C_OFF;
      out_active <= r_s1_active;
    end
  end

endmodule

// File: doc/pattern_gen.md
Name: pattern_gen

Overview:
Parametrised, pipelined video test-pattern generator for the HDMI path. It sits between the timing generator, which supplies pixel_x, pixel_y, active and frame_start, and the TMDS encoder. It supports five selectable patterns: exact-width colour bars, grey ramp, checkerboard, bouncing box and solid colour. The mode is latched only at frame boundaries, and the bouncing box is animated by per-frame state.

Parameters:
H_ACTIVE, 480, active pixels per line
V_ACTIVE, 272, active lines per frame
COORD_W, 10, width of pixel_x/pixel_y
COLOR_W, 8, bits per colour channel
NUM_BARS, 8, colour bar count, legal range 1..8; bar width BAR_W = H_ACTIVE/NUM_BARS (integer)
CHECK_LOG2, 5, checker square size = 2^CHECK_LOG2 pixels
BOX_SIZE, 32, bouncing box edge length in pixels
RAMP_SHIFT, 1, ramp value = (pixel_x >> RAMP_SHIFT) truncated to COLOR_W

Ports:
clk  in  1  pixel clock
rst_n  in  1  asynchronous active-low reset
pixel_x  in  COORD_W  current column; increments by 1 each active cycle
pixel_y  in  COORD_W  current row
active  in  1  pixel is in the visible area
frame_start  in  1  one-cycle pulse before the first active pixel of a frame
mode  in  3  pattern select; sampled only on frame_start
solid_rgb  in  3*COLOR_W  {R,G,B} for solid mode; sampled only on frame_start
red, green, blue  out  COLOR_W each  registered pixel colour
out_active  out  1  active delayed to align with the colour outputs

Behaviour:
- Reset (rst_n low, asynchronous): red/green/blue = 0, out_active = 0. All pipeline registers are cleared. mode_q = 0. Box is at (0,0) with dx = dy = +1. Bar counters = 0.
- Latency is exactly 2 clk from the inputs to red/green/blue/out_active. Stage 1 registers coordinates, active and bar index. Stage 2 registers colour.
- If the stage-2 active is 0, the RGB outputs are 0 regardless of mode.
- Mode and solid_rgb are latched into mode_q/solid_q on a cycle where frame_start = 1. Changes at any other time are ignored until the next frame_start.
- Mode 0, bars:
  - Counters pix_in_bar and bar_idx clear whenever active = 0.
  - While active, pix_in_bar increments; at BAR_W-1 it wraps to 0 and bar_idx increments, saturating at NUM_BARS-1.
  - Colour from bar_idx: 0 white, 1 yellow, 2 cyan, 3 green, 4 magenta, 5 red, 6 blue, 7 black.
  - Full-scale components are all-ones (2^COLOR_W - 1); off components are 0.
- Mode 1, ramp: R = G = B = (pixel_x >> RAMP_SHIFT)[COLOR_W-1:0].
- Mode 2, checker: white if pixel_x[CHECK_LOG2] XOR pixel_y[CHECK_LOG2] = 1, else black.
- Mode 3, box: white where box_x <= pixel_x < box_x+BOX_SIZE and box_y <= pixel_y < box_y+BOX_SIZE; blue elsewhere.
  - Box state updates on each frame_start: box_x += dx, box_y += dy.
  - Boundary rule: if box_x = H_ACTIVE-BOX_SIZE and dx = +1, dx becomes -1 and box_x decrements. If box_x = 0 and dx = -1, dx becomes +1 and box_x increments. The same rule applies on y with V_ACTIVE.
  - The box never leaves the visible area. It animates in all modes, so position is continuous when switching modes.
- Mode 4, solid: output solid_q.
- Modes 5..7: black (active remains propagated).
- frame_start coincident with active = 1 is illegal input; behaviour is unspecified, but no X is permitted on the outputs.
- Reset mid-frame: the outputs go to 0 immediately. Patterns resume in mode 0 at the next active pixel, with bar counters restarting on the next active rising edge.

Optional Feature:
PATTERN_GEN_BORDER_EN:
- Defined: any active pixel with pixel_x = 0, pixel_x = H_ACTIVE-1, pixel_y = 0 or pixel_y = V_ACTIVE-1 is forced to white (all-ones) in every mode, overriding the pattern. Latency is unchanged.
- Undefined: no border logic; the pattern is output unmodified.

Test Plan:
- Reset: hold rst_n = 0 while active = 1 -> red/green/blue = 0, out_active = 0. Release, frame_start with mode = 0, pixel_x = 0 active -> 2 clk later RGB = FF,FF,FF.
- Bars, default parameters: sweep one line of 480 active pixels -> x = 59 white, x = 60 yellow, x = 119 yellow, x = 120 cyan, x = 479 black. Exactly 60 pixels per bar; no residual bar at line end.
- Mode latch: set mode = 2 mid-frame -> bars persist for the rest of the frame. After the next frame_start, x = 32, y = 0 gives FF,FF,FF and x = 32, y = 32 gives 00,00,00.
- Box bounce, V_ACTIVE = 272, BOX_SIZE = 32: 240 frame_starts from reset -> box_y = 240. The next frame gives box_y = 239 and dy = -1. box_x at 448 reverses identically.
- Ramp/solid/illegal: mode 1, x = 300 -> RGB = 96h each. Mode 4 with solid_rgb = 123456h -> 12,34,56. Mode 6 -> 0,0,0 with out_active = 1.
- With PATTERN_GEN_BORDER_EN defined, mode 6 -> x = 0 or y = 271 pixels are FF,FF,FF and interior pixels are 0. Without it, all pixels are 0.
